// File: rtl/md_pkg.sv
// md_pkg: decode constants, cycle defaults and state encoding for the multiply/divide unit
package md_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W        = 4;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/md_decode.sv
// md_decode: classifies an instruction word into the eight multiply/divide operations
module md_decode import md_pkg::*; (
    input  logic [31:0] ir,
    output logic        is_mult,
    output logic        is_multu,
    output logic        is_div,
    output logic        is_divu,
    output logic        is_mfhi,
    output logic        is_mflo,
    output logic        is_mthi,
    output logic        is_mtlo,
    output logic        is_md
);
    logic sp;
    logic unused_ir;
    assign unused_ir = ^ir[25:6];
    assign sp        = ir[31:26] == OP_SPECIAL;
    assign is_mult   = sp && ir[5:0] == FN_MULT;
    assign is_multu  = sp && ir[5:0] == FN_MULTU;
    assign is_div    = sp && ir[5:0] == FN_DIV;
    assign is_divu   = sp && ir[5:0] == FN_DIVU;
    assign is_mfhi   = sp && ir[5:0] == FN_MFHI;
    assign is_mflo   = sp && ir[5:0] == FN_MFLO;
    assign is_mthi   = sp && ir[5:0] == FN_MTHI;
    assign is_mtlo   = sp && ir[5:0] == FN_MTLO;
    assign is_md     = is_mult | is_multu | is_div | is_divu | is_mfhi | is_mflo | is_mthi | is_mtlo;
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div sequencer owning HI/LO, with pipeline stall request
module md_ctrl import md_pkg::*; #(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic e_mult, e_multu, e_div, e_divu, e_mfhi, e_mflo, e_mthi, e_mtlo, e_unused;
    logic d_md;
    logic [7:0] d_unused;
    logic e_mul, e_op, div_z, commit, res_ok;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    state_t state;
    logic [63:0] prod;
    logic [31:0] dvd, dvs, q_mag, r_mag, res_hi, res_lo, res_hi_n, res_lo_n;

    md_decode u_dec_d (
        .ir(IR_D), .is_mult(d_unused[0]), .is_multu(d_unused[1]), .is_div(d_unused[2]),
        .is_divu(d_unused[3]), .is_mfhi(d_unused[4]), .is_mflo(d_unused[5]),
        .is_mthi(d_unused[6]), .is_mtlo(d_unused[7]), .is_md(d_md)
    );

    md_decode u_dec_e (
        .ir(IR_E), .is_mult(e_mult), .is_multu(e_multu), .is_div(e_div), .is_divu(e_divu),
        .is_mfhi(e_mfhi), .is_mflo(e_mflo), .is_mthi(e_mthi), .is_mtlo(e_mtlo), .is_md(e_unused)
    );

    assign e_mul = e_mult | e_multu;
    assign e_op  = e_mul | e_div | e_divu;
    assign div_z = rt_E == '0;

    // One multiplier and one magnitude divider serve both signed and unsigned forms
    always_comb begin
        prod     = {{32{e_mult & rs_E[31]}}, rs_E} * {{32{e_mult & rt_E[31]}}, rt_E};
        dvd      = (e_div && rs_E[31]) ? -rs_E : rs_E;
        dvs      = div_z ? 32'd1 : (e_div && rt_E[31]) ? -rt_E : rt_E;
        q_mag    = dvd / dvs;
        r_mag    = dvd % dvs;
        res_lo_n = e_mul ? prod[31:0] : (e_div && (rs_E[31] ^ rt_E[31])) ? -q_mag : q_mag;
        res_hi_n = e_mul ? prod[63:32] : (e_div && rs_E[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        cnt_nxt = start ? (e_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC))
                : state == BUSY ? cnt - CNT_W'(1) : cnt;
        commit  = state == BUSY && cnt == CNT_W'(1) && res_ok;
    end

    always_comb begin
        state  = cnt != '0 ? BUSY : IDLE;
        busy   = state == BUSY;
        start  = e_op && state == IDLE;
        stall  = d_md && (start || busy);
        md_out = e_mfhi ? hi : e_mflo ? lo : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_ok <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (start) begin
                res_hi <= res_hi_n;
                res_lo <= res_lo_n;
                res_ok <= !((e_div || e_divu) && div_z);
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (state == IDLE && e_mthi) hi <= rs_E;
            if (state == IDLE && e_mtlo) lo <= rs_E;
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl launch, countdown, HI/LO commit and stall
module tb_md_ctrl;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1a, DIVU = 6'h1b;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13, ADDU = 6'h21;
    localparam logic [31:0] NOP = 32'h0;

    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] IR_D = '0, IR_E = '0, rs_E = '0, rt_E = '0;
    logic start, busy, stall;
    logic [31:0] md_out, hi, lo;

    typedef struct {
        string tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int n;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0, illegal = 0, busy_run = 0;
    logic prev_busy = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;

    md_ctrl dut (
        .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .rs_E(rs_E), .rt_E(rt_E),
        .start(start), .busy(busy), .stall(stall), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [31:0] ins(input logic [5:0] fn);
        return {26'b0, fn};
    endfunction

    function automatic logic is_md_ins(input logic [31:0] ir);
        return ir[31:26] == 6'b0 && (ir[5:2] == 4'b0100 || ir[5:2] == 4'b0110);
    endfunction

    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, b, h, l);
        longint sa, sb_, ma, mb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (fn == MULT) return 64'(sa * sb_);
        if (fn == MULTU) return ua * ub;
        if (b == 0) return {h, l};
        if (fn == DIVU) return {a % b, a / b};
        ma = sa < 0 ? -sa : sa;
        mb = sb_ < 0 ? -sb_ : sb_;
        q = ma / mb;
        if ((sa < 0) != (sb_ < 0)) q = -q;
        r = sa - q * sb_;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic retire(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow got=busy_fall exp=no_pending_op");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".cycles"}, 32'(n), 32'(e.n));
        chk({e.tag, ".hi"}, hi, e.hi);
        chk({e.tag, ".lo"}, lo, e.lo);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_busy <= 1'b0;
            busy_run <= 0;
        end else begin
            if (busy && is_md_ins(IR_E)) illegal <= illegal + 1;
            if (busy) busy_run <= busy_run + 1;
            else begin
                if (prev_busy) retire(busy_run);
                busy_run <= 0;
            end
            prev_busy <= busy;
        end
    end

    task automatic go(input string tag, input logic [31:0] ird, ire, rs, rt,
                      input logic e_start, e_busy, e_stall, input logic [31:0] e_md);
        IR_D = ird;
        IR_E = ire;
        rs_E = rs;
        rt_E = rt;
        @(negedge clk);
        chk({tag, ".start"}, 32'(start), 32'(e_start));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".md_out"}, md_out, e_md);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [5:0] fn, input logic [31:0] rs, rt, ird,
                      input logic st);
        exp_t e;
        logic [63:0] r;
        int n;
        n = (fn == MULT || fn == MULTU) ? 5 : 10;
        r = model(fn, rs, rt, m_hi, m_lo);
        {m_hi, m_lo} = r;
        e.tag = tag;
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.n = n;
        sb.push_back(e);
        go({tag, ".launch"}, ird, ins(fn), rs, rt, 1'b1, 1'b0, st, '0);
        for (int i = 0; i < n; i++) go({tag, ".run"}, ird, NOP, '0, '0, 1'b0, 1'b1, st, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.start", 32'(start), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.stall", 32'(stall), 0);
        chk("rst.md_out", md_out, 0);
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        op("mult", MULT, 32'h3, 32'hFFFFFFFE, NOP, 1'b0);
        chk("mult.hi_const", hi, 32'hFFFFFFFF);
        chk("mult.lo_const", lo, 32'hFFFFFFFA);
        op("div", DIV, 32'hFFFFFFF9, 32'h2, NOP, 1'b0);
        chk("div.lo_const", lo, 32'hFFFFFFFD);
        chk("div.hi_const", hi, 32'hFFFFFFFF);
        op("divu", DIVU, 32'hFFFFFFF9, 32'h2, NOP, 1'b0);
        chk("divu.lo_const", lo, 32'h7FFFFFFC);
        chk("divu.hi_const", hi, 32'h00000001);

        go("mthi", NOP, ins(MTHI), 32'h11, '0, 1'b0, 1'b0, 1'b0, '0);
        m_hi = 32'h11;
        go("mtlo", NOP, ins(MTLO), 32'h22, '0, 1'b0, 1'b0, 1'b0, '0);
        m_lo = 32'h22;
        op("divu0", DIVU, 32'h5, 32'h0, NOP, 1'b0);
        chk("divu0.hi_kept", hi, 32'h11);
        chk("divu0.lo_kept", lo, 32'h22);

        op("mult_st", MULT, 32'd7, 32'd6, ins(MFLO), 1'b1);
        go("mflo_d", ins(MFLO), NOP, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        go("mflo_e", NOP, ins(MFLO), '0, '0, 1'b0, 1'b0, 1'b0, 32'd42);
        op("mult_addu", MULT, 32'd9, 32'd9, ins(ADDU), 1'b0);

        go("mthi2", ins(MFHI), ins(MTHI), 32'hDEADBEEF, '0, 1'b0, 1'b0, 1'b0, '0);
        m_hi = 32'hDEADBEEF;
        chk("mthi2.hi", hi, 32'hDEADBEEF);
        go("mfhi", NOP, ins(MFHI), '0, '0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, NOP, 1'b0);
        chk("multu.hi_const", hi, 32'hFFFFFFFE);
        chk("multu.lo_const", lo, 32'h00000001);
        op("div_neg", DIV, 32'd7, 32'hFFFFFFFE, NOP, 1'b0);
        op("div_min", DIV, 32'h80000000, 32'hFFFFFFFF, NOP, 1'b0);

        go("rst_launch", ins(MFLO), ins(DIV), 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) go("rst_run", ins(MFLO), NOP, '0, '0, 1'b0, 1'b1, 1'b1, '0);
        reset = 1'b1;
        #1;
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.stall", 32'(stall), 0);
        chk("rst_mid.start", 32'(start), 0);
        chk("rst_mid.hi", hi, 0);
        chk("rst_mid.lo", lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        op("mult_rst", MULT, 32'hFFFFFFFB, 32'd3, NOP, 1'b0);
        chk("mult_rst.hi_const", hi, 32'hFFFFFFFF);
        chk("mult_rst.lo_const", lo, 32'hFFFFFFF1);
        go("tail", NOP, NOP, '0, '0, 1'b0, 1'b0, 1'b0, '0);

        chk("no_md_in_e_while_busy", 32'(illegal), 0);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
